// File: rtl/dqn_ctrl_pkg.sv
// dqn_ctrl_pkg: shared ctrl/step bus codes, sequencer state encoding and layer-index width
// Imported by the training sequencer and by the bias/weight register blocks that decode
// the 4-bit ctrl bus.
package dqn_ctrl_pkg;
   localparam int STEP_W = 4;
   localparam logic [3:0] CTRL_IDLE = 4'b0000;
   localparam logic [3:0] CTRL_FWD  = 4'b0001;
   localparam logic [3:0] CTRL_BWD  = 4'b0010;
   localparam logic [3:0] CTRL_UPD  = 4'b0011;
   localparam logic [3:0] CTRL_FIN  = 4'b0100;
   localparam logic [3:0] CTRL_ERR  = 4'b1111;
   typedef enum logic [2:0] {ST_IDLE, ST_FWD, ST_BWD, ST_UPD, ST_FIN, ST_ERR} state_t;
   function automatic logic [3:0] ctrl_of(input state_t s);
      return (s == ST_FWD) ? CTRL_FWD : (s == ST_BWD) ? CTRL_BWD : (s == ST_UPD) ? CTRL_UPD :
             (s == ST_FIN) ? CTRL_FIN : (s == ST_ERR) ? CTRL_ERR : CTRL_IDLE;
   endfunction
endpackage

// File: rtl/seq_step_cnt.sv
// seq_step_cnt: up/down/load layer counter with terminal flags
// Ports: clk, rst (sync, active-high); i_clr/i_load/i_up/i_dn commands in that priority;
//        i_load_val load value; o_cnt current index; o_at_first (cnt==0); o_at_last (cnt==N-1).
module seq_step_cnt #(
   parameter int N = 3,
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_clr,
   input  logic         i_load,
   input  logic [W-1:0] i_load_val,
   input  logic         i_up,
   input  logic         i_dn,
   output logic [W-1:0] o_cnt,
   output logic         o_at_first,
   output logic         o_at_last
);
   logic [W-1:0] r_cnt;
   always_ff @(posedge clk) begin
      if (rst || i_clr) r_cnt <= '0;
      else if (i_load) r_cnt <= i_load_val;
      else if (i_up) r_cnt <= r_cnt + 1'b1;
      else if (i_dn) r_cnt <= r_cnt - 1'b1;
   end
   assign o_cnt      = r_cnt;
   assign o_at_first = (r_cnt == '0);
   assign o_at_last  = (r_cnt == W'(N - 1));
endmodule

// File: rtl/train_seq_ctrl.sv
// train_seq_ctrl: forward/backward/update phase sequencer for the DQN training datapath
// Ports: clk, rst (sync, active-high); i_start, i_abort, i_layer_done (datapath handshake);
//        o_ctrl phase code, o_step layer index, o_sel one-hot update select, o_busy, o_done pulse,
//        o_iter completed iterations, o_err sticky timeout flag.
// Build option: define TRAIN_SEQ_TIMEOUT_EN to add the layer_done wait timeout and ERR state;
//        without it the sequencer waits indefinitely and o_err is tied low.
import dqn_ctrl_pkg::*;
module train_seq_ctrl #(
   parameter int N_LAYERS = 3,
   parameter int N_ITERS  = 4
`ifdef TRAIN_SEQ_TIMEOUT_EN
   , parameter int TIMEOUT = 1023
`endif
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_start,
   input  logic              i_abort,
   input  logic              i_layer_done,
   output logic [3:0]        o_ctrl,
   output logic [STEP_W-1:0] o_step,
   output logic [3:0]        o_sel,
   output logic              o_busy,
   output logic              o_done,
   output logic [15:0]       o_iter,
   output logic              o_err
);
   state_t r_state, w_nxt;
   logic [15:0] r_iter;
   logic [3:0]  r_ctrl, r_sel;
   logic        r_busy, r_done;
   logic        w_clr, w_up, w_dn, w_iter_inc, w_iter_clr, w_at_first, w_at_last;
   logic        w_wait_to;
   seq_step_cnt #(.N(N_LAYERS), .W(STEP_W)) u_step (
      .clk        (clk),
      .rst        (rst),
      .i_clr      (w_clr),
      .i_load     (1'b0),
      .i_load_val ('0),
      .i_up       (w_up),
      .i_dn       (w_dn),
      .o_cnt      (o_step),
      .o_at_first (w_at_first),
      .o_at_last  (w_at_last)
   );
`ifdef TRAIN_SEQ_TIMEOUT_EN
   logic [9:0] r_wait;
   logic       r_err;
   // Restarts on every phase change and every handshake, so it measures one layer's wait.
   always_ff @(posedge clk) begin
      if (rst || w_nxt != r_state || i_layer_done) r_wait <= '0;
      else if (r_state == ST_FWD || r_state == ST_BWD) r_wait <= r_wait + 10'd1;
   end
   assign w_wait_to = (r_state == ST_FWD || r_state == ST_BWD) && !i_layer_done &&
                      (r_wait == 10'(TIMEOUT - 1));
   always_ff @(posedge clk) r_err <= !rst && (w_nxt == ST_ERR);
   assign o_err = r_err;
`else
   assign w_wait_to = 1'b0;
   assign o_err     = 1'b0;
`endif
   always_comb begin
      w_nxt      = r_state;
      w_clr      = 1'b0;
      w_up       = 1'b0;
      w_dn       = 1'b0;
      w_iter_inc = 1'b0;
      w_iter_clr = 1'b0;
      if (i_abort) begin
         w_nxt = ST_IDLE;
         w_clr = 1'b1;
      end else if (w_wait_to) begin
         w_nxt = ST_ERR;
      end else begin
         case (r_state)
            ST_IDLE: if (i_start) begin
               w_nxt      = ST_FWD;
               w_clr      = 1'b1;
               w_iter_clr = 1'b1;
            end
            ST_FWD: if (i_layer_done) begin
               w_nxt = w_at_last ? ST_BWD : ST_FWD;
               w_up  = !w_at_last;
            end
            ST_BWD: if (i_layer_done) begin
               w_nxt = w_at_first ? ST_UPD : ST_BWD;
               w_dn  = !w_at_first;
            end
            ST_UPD: begin
               w_up       = !w_at_last;
               w_clr      = w_at_last;
               w_iter_inc = w_at_last;
               if (w_at_last) w_nxt = (32'(r_iter) + 32'd1 < 32'(N_ITERS)) ? ST_FWD : ST_FIN;
            end
            ST_FIN:  w_nxt = ST_IDLE;
            default: w_nxt = r_state;
         endcase
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_iter  <= '0;
         r_ctrl  <= CTRL_IDLE;
         r_sel   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_nxt;
         r_iter  <= w_iter_clr ? '0 : r_iter + 16'(w_iter_inc);
         r_ctrl  <= ctrl_of(w_nxt);
         // Update select walks as a shift register alongside the step counter.
         r_sel   <= (w_nxt != ST_UPD) ? '0 : (r_state == ST_UPD) ? r_sel << 1 : 4'b0001;
         r_busy  <= (w_nxt != ST_IDLE);
         r_done  <= (w_nxt == ST_FIN);
      end
   end
   assign o_ctrl = r_ctrl;
   assign o_sel  = r_sel;
   assign o_busy = r_busy;
   assign o_done = r_done;
   assign o_iter = r_iter;
endmodule
